// File: rtl/vote_result_reader.sv
// ---------------------------------------------------------------------------
// vote_result_reader
//
// Read side of the vote-counting logger. When the machine enters result
// display mode it freezes the four live tallies into snapshot registers and
// walks them one per clock. The walk finds the highest tally, the lowest
// index holding it, whether that maximum is shared, and the total count.
// After the walk it drives one candidate's frozen count onto the display
// path. The buttons pick that candidate.
//
// Build option:
//   AUTO_CYCLE_EN - when defined, the display steps through the candidates
//                   by itself every DWELL_CYCLES clocks while no button is
//                   held. A button press restarts the dwell period.
//
// Ports:
//   clk, reset        clock; synchronous active-high reset
//   mode              0 = vote registering, 1 = result display
//   cand1..4_count    live tallies (CNT_W bits each)
//   cand1..4_button   display-select requests, level-sampled, cand1 highest
//   display_value     frozen count of the selected candidate
//   display_sel       index of the selected candidate (0 = cand1)
//   winner_idx        index of the highest tally (lowest index on a tie)
//   winner_tie        two or more candidates share the maximum
//   total_votes       sum of the four frozen tallies (CNT_W+2 bits)
//   result_valid      winner_idx / winner_tie / total_votes are valid
//   busy              scan in progress
//
// Every output is a register.
// ---------------------------------------------------------------------------
module vote_result_reader #(
  parameter int CNT_W        = 8,
  parameter int DWELL_CYCLES = 100
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mode,
  input  logic [CNT_W-1:0] cand1_count,
  input  logic [CNT_W-1:0] cand2_count,
  input  logic [CNT_W-1:0] cand3_count,
  input  logic [CNT_W-1:0] cand4_count,
  input  logic             cand1_button,
  input  logic             cand2_button,
  input  logic             cand3_button,
  input  logic             cand4_button,
  output logic [CNT_W-1:0] display_value,
  output logic [1:0]       display_sel,
  output logic [1:0]       winner_idx,
  output logic             winner_tie,
  output logic [CNT_W+1:0] total_votes,
  output logic             result_valid,
  output logic             busy
);

  // The auto-cycle dwell counter needs at least two states.
  if (DWELL_CYCLES < 2) begin : g_dwell_check
    $error("DWELL_CYCLES must be at least 2");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    SHOW = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  // Frozen tallies and the running scan result.
  logic [CNT_W-1:0] snap [4];
  logic [1:0]       scan_idx;
  logic [CNT_W-1:0] run_max;
  logic [1:0]       run_win;
  logic             run_tie;
  logic [CNT_W+1:0] run_total;

  // Result of folding the candidate at scan_idx into the running values.
  logic [CNT_W-1:0] scan_cur;
  logic [CNT_W-1:0] max_next;
  logic [1:0]       win_next;
  logic             tie_next;
  logic [CNT_W+1:0] total_next;

  // Button priority encoder.
  logic             btn_any;
  logic [1:0]       btn_idx;

`ifdef AUTO_CYCLE_EN
  localparam int DW_W = (DWELL_CYCLES > 2) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(DWELL_CYCLES - 1);
  logic [DW_W-1:0] dwell_cnt;
`endif

  // -------------------------------------------------------------------------
  // One scan step. Index 0 seeds the running values. Later indices replace
  // the winner only on a strictly greater tally, so the lowest index keeps a
  // shared maximum and only the tie flag records it.
  // -------------------------------------------------------------------------
  always_comb begin
    scan_cur   = snap[scan_idx];
    max_next   = run_max;
    win_next   = run_win;
    tie_next   = run_tie;
    total_next = run_total + {2'b00, scan_cur};
    if (scan_idx == 2'd0) begin
      max_next   = scan_cur;
      win_next   = 2'd0;
      tie_next   = 1'b0;
      total_next = {2'b00, scan_cur};
    end else if (scan_cur > run_max) begin
      max_next = scan_cur;
      win_next = scan_idx;
      tie_next = 1'b0;
    end else if (scan_cur == run_max) begin
      tie_next = 1'b1;
    end
  end

  always_comb begin
    btn_any = 1'b1;
    btn_idx = 2'd0;
    if (cand1_button)      btn_idx = 2'd0;
    else if (cand2_button) btn_idx = 2'd1;
    else if (cand3_button) btn_idx = 2'd2;
    else if (cand4_button) btn_idx = 2'd3;
    else                   btn_any = 1'b0;
  end

  // -------------------------------------------------------------------------
  // State register and next-state logic. Leaving display mode always returns
  // to IDLE, so the next entry rescans fresh tallies.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (mode) state_next = SCAN;
      SCAN: begin
        if (!mode)                  state_next = IDLE;
        else if (scan_idx == 2'd3)  state_next = SHOW;
      end
      SHOW: if (!mode) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath. The running scan values stay internal. The visible results
  // load only on the last scan step, so an aborted scan leaves the outputs
  // at zero.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) snap[i] <= '0;
      scan_idx      <= '0;
      run_max       <= '0;
      run_win       <= '0;
      run_tie       <= 1'b0;
      run_total     <= '0;
      display_value <= '0;
      display_sel   <= '0;
      winner_idx    <= '0;
      winner_tie    <= 1'b0;
      total_votes   <= '0;
      result_valid  <= 1'b0;
      busy          <= 1'b0;
`ifdef AUTO_CYCLE_EN
      dwell_cnt     <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (mode) begin
            snap[0]  <= cand1_count;
            snap[1]  <= cand2_count;
            snap[2]  <= cand3_count;
            snap[3]  <= cand4_count;
            scan_idx <= 2'd0;
            busy     <= 1'b1;
          end
        end

        SCAN: begin
          if (!mode) begin
            display_value <= '0;
            display_sel   <= '0;
            winner_idx    <= '0;
            winner_tie    <= 1'b0;
            total_votes   <= '0;
            result_valid  <= 1'b0;
            busy          <= 1'b0;
          end else begin
            run_max   <= max_next;
            run_win   <= win_next;
            run_tie   <= tie_next;
            run_total <= total_next;
            scan_idx  <= scan_idx + 2'd1;
            if (scan_idx == 2'd3) begin
              busy          <= 1'b0;
              result_valid  <= 1'b1;
              winner_idx    <= win_next;
              winner_tie    <= tie_next;
              total_votes   <= total_next;
              display_sel   <= win_next;
              display_value <= snap[win_next];
`ifdef AUTO_CYCLE_EN
              dwell_cnt     <= '0;
`endif
            end
          end
        end

        SHOW: begin
          if (!mode) begin
            display_value <= '0;
            display_sel   <= '0;
            winner_idx    <= '0;
            winner_tie    <= 1'b0;
            total_votes   <= '0;
            result_valid  <= 1'b0;
            busy          <= 1'b0;
`ifdef AUTO_CYCLE_EN
            dwell_cnt     <= '0;
`endif
          end else if (btn_any) begin
            display_sel   <= btn_idx;
            display_value <= snap[btn_idx];
`ifdef AUTO_CYCLE_EN
            dwell_cnt     <= '0;
`endif
          end
`ifdef AUTO_CYCLE_EN
          else if (dwell_cnt == DWELL_LAST) begin
            display_sel   <= display_sel + 2'd1;
            display_value <= snap[display_sel + 2'd1];
            dwell_cnt     <= '0;
          end else begin
            dwell_cnt <= dwell_cnt + 1'b1;
          end
`endif
        end

        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vote_result_reader.sv
// ---------------------------------------------------------------------------
// tb_vote_result_reader
//
// Directed bench for vote_result_reader. A behavioural model tracks what the
// display should show from mode, the tallies and the buttons. It works out
// the winner, tie and total in one step from the frozen tallies. A compare
// process checks all outputs against the model on every falling edge.
// Directed sequences also check hand-computed literal results.
// ---------------------------------------------------------------------------
module tb_vote_result_reader;

  localparam int CNT_W = 8;
  localparam int DW    = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic             mode = 1'b0;
  logic [CNT_W-1:0] cand1_count = '0, cand2_count = '0, cand3_count = '0, cand4_count = '0;
  logic             cand1_button = 1'b0, cand2_button = 1'b0, cand3_button = 1'b0, cand4_button = 1'b0;
  logic [CNT_W-1:0] display_value;
  logic [1:0]       display_sel;
  logic [1:0]       winner_idx;
  logic             winner_tie;
  logic [CNT_W+1:0] total_votes;
  logic             result_valid;
  logic             busy;

  vote_result_reader #(.CNT_W(CNT_W), .DWELL_CYCLES(DW)) dut (
    .clk(clk), .reset(reset), .mode(mode),
    .cand1_count(cand1_count), .cand2_count(cand2_count),
    .cand3_count(cand3_count), .cand4_count(cand4_count),
    .cand1_button(cand1_button), .cand2_button(cand2_button),
    .cand3_button(cand3_button), .cand4_button(cand4_button),
    .display_value(display_value), .display_sel(display_sel),
    .winner_idx(winner_idx), .winner_tie(winner_tie),
    .total_votes(total_votes), .result_valid(result_valid), .busy(busy)
  );

  int n_checks = 0;
  int n_pass   = 0;
  bit cmp_on   = 1'b0;

  task automatic check(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // phase: 0 idle, 1 scanning, 2 showing
  int          m_phase = 0;
  int          m_left  = 0;
  int          m_dwell = 0;
  int unsigned m_snap [4];
  int unsigned e_val = 0, e_sel = 0, e_win = 0, e_tie = 0, e_tot = 0, e_valid = 0, e_busy = 0;

  task automatic model_clear();
    e_val = 0; e_sel = 0; e_win = 0; e_tie = 0; e_tot = 0; e_valid = 0; e_busy = 0;
    m_dwell = 0;
  endtask

  task automatic model_results();
    int best, shared;
    int unsigned sum;
    best = 0; sum = 0; shared = 0;
    for (int i = 0; i < 4; i++) begin
      sum += m_snap[i];
      if (m_snap[i] > m_snap[best]) best = i;
    end
    for (int i = 0; i < 4; i++) if (m_snap[i] == m_snap[best]) shared++;
    e_win = best; e_tie = (shared >= 2) ? 1 : 0; e_tot = sum;
    e_sel = best; e_val = m_snap[best];
    e_valid = 1; e_busy = 0; m_dwell = 0;
  endtask

  always @(posedge clk) begin
    if (reset) begin
      m_phase = 0;
      model_clear();
    end else if (m_phase == 0) begin
      if (mode) begin
        m_snap[0] = cand1_count; m_snap[1] = cand2_count;
        m_snap[2] = cand3_count; m_snap[3] = cand4_count;
        m_left = 4; e_busy = 1; m_phase = 1;
      end
    end else if (!mode) begin
      model_clear();
      m_phase = 0;
    end else if (m_phase == 1) begin
      m_left--;
      if (m_left == 0) begin
        model_results();
        m_phase = 2;
      end
    end else begin
      if (cand1_button || cand2_button || cand3_button || cand4_button) begin
        e_sel = cand1_button ? 0 : cand2_button ? 1 : cand3_button ? 2 : 3;
        e_val = m_snap[e_sel];
        m_dwell = 0;
      end
`ifdef AUTO_CYCLE_EN
      else if (m_dwell == DW - 1) begin
        e_sel = (e_sel + 1) % 4;
        e_val = m_snap[e_sel];
        m_dwell = 0;
      end else m_dwell++;
`endif
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (cmp_on) begin
      check("m_display_value", display_value, e_val);
      check("m_display_sel",   display_sel,   e_sel);
      check("m_winner_idx",    winner_idx,    e_win);
      check("m_winner_tie",    winner_tie,    e_tie);
      check("m_total_votes",   total_votes,   e_tot);
      check("m_result_valid",  result_valid,  e_valid);
      check("m_busy",          busy,          e_busy);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_counts(input int a, input int b, input int c, input int d);
    cand1_count = CNT_W'(a); cand2_count = CNT_W'(b);
    cand3_count = CNT_W'(c); cand4_count = CNT_W'(d);
  endtask

  task automatic go_idle();
    @(negedge clk); mode = 1'b0;
    @(negedge clk);
  endtask

  // Raises mode with the given tallies, then checks busy width, result
  // latency and the literal results.
  task automatic run_scan(input int a, input int b, input int c, input int d,
                          input int ew, input int et, input int etot, input int edv,
                          input string nm);
    int busy_cycles, valid_at;
    @(negedge clk);
    set_counts(a, b, c, d);
    mode = 1'b1;
    busy_cycles = 0; valid_at = 0;
    for (int i = 1; i <= 10 && valid_at == 0; i++) begin
      @(negedge clk);
      if (busy) busy_cycles++;
      if (result_valid) valid_at = i;
    end
    check({nm, "_busy_cycles"}, busy_cycles, 4);
    check({nm, "_valid_edge"},  valid_at,    5);
    check({nm, "_winner"},      winner_idx,  ew);
    check({nm, "_tie"},         winner_tie,  et);
    check({nm, "_total"},       total_votes, etot);
    check({nm, "_sel"},         display_sel, ew);
    check({nm, "_value"},       display_value, edv);
  endtask

  task automatic pulse_buttons(input logic b1, input logic b2, input logic b3, input logic b4);
    @(negedge clk);
    cand1_button = b1; cand2_button = b2; cand3_button = b3; cand4_button = b4;
    @(negedge clk);
    cand1_button = 1'b0; cand2_button = 1'b0; cand3_button = 1'b0; cand4_button = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    repeat (2) @(posedge clk);
    cmp_on = 1'b1;
    @(negedge clk);
    check("rst_valid", result_valid, 0);
    check("rst_busy",  busy, 0);
    check("rst_total", total_votes, 0);
    reset = 1'b0;

    run_scan(3, 7, 2, 5, 1, 0, 17, 7, "s3725");

`ifndef AUTO_CYCLE_EN
    pulse_buttons(1'b0, 1'b0, 1'b1, 1'b0);
    check("btn3_sel", display_sel, 2);
    check("btn3_val", display_value, 2);
    pulse_buttons(1'b0, 1'b1, 1'b0, 1'b1);
    check("btn24_sel", display_sel, 1);
    check("btn24_val", display_value, 7);
    @(negedge clk); cand1_count = 8'd100;
    repeat (2) @(negedge clk);
    check("live_ignored_val", display_value, 7);
    pulse_buttons(1'b1, 1'b0, 1'b0, 1'b0);
    check("btn1_frozen_val", display_value, 3);
`else
    // Winner 1 shown; four dwell cycles later the display moves to 2.
    repeat (4) @(negedge clk);
    check("auto_sel_2", display_sel, 2);
    repeat (4) @(negedge clk);
    check("auto_sel_3", display_sel, 3);
    pulse_buttons(1'b1, 1'b0, 1'b0, 1'b0);
    check("auto_btn1", display_sel, 0);
    repeat (3) @(negedge clk);
    check("auto_hold", display_sel, 0);
    @(negedge clk);
    check("auto_after", display_sel, 1);
`endif

    go_idle();
    check("idle_valid", result_valid, 0);
    check("idle_sel", display_sel, 0);
    run_scan(9, 4, 9, 9, 0, 1, 31, 9, "s9499");
    go_idle();
    run_scan(0, 0, 0, 0, 0, 1, 0, 0, "s0000");
    go_idle();
    run_scan(255, 255, 255, 255, 0, 1, 1020, 255, "s255");
    go_idle();
    run_scan(1, 2, 3, 200, 3, 0, 206, 200, "s_last");
    go_idle();

    // Abort: drop mode during the second scan cycle.
    @(negedge clk); set_counts(3, 7, 2, 5); mode = 1'b1;
    @(negedge clk);
    @(negedge clk); mode = 1'b0;
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_valid", result_valid, 0);
    check("abort_total", total_votes, 0);
    check("abort_winner", winner_idx, 0);
    run_scan(1, 2, 8, 4, 2, 0, 15, 8, "s_rescan");

    // Reset in the middle of a scan.
    go_idle();
    @(negedge clk); set_counts(10, 20, 30, 40); mode = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b1; mode = 1'b0;
    @(negedge clk);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_valid", result_valid, 0);
    reset = 1'b0;
    run_scan(10, 20, 30, 40, 3, 0, 100, 40, "s_after_rst");

    repeat (2) @(negedge clk);
    cmp_on = 1'b0;
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
